// File: rtl/rate_tracking_lockable_pkg.sv
// Shared clock-domain bundle plus lock-state type and default lock constants
// for the half-rate tracker.
package common_p;
    typedef struct packed {
        logic clk;
        logic sync_rst;
        logic clk_en;
    } clk_dom_s;
endpackage

package clks_alot_p;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACQUIRE  = 2'd1,
        TRACK    = 2'd2,
        HOLDOVER = 2'd3
    } rate_track_state_e;

    localparam int unsigned LOCK_COUNT_DEF = 4;
    localparam int unsigned ERR_TOL_DEF    = 2;
    localparam int unsigned MISS_LIMIT_DEF = 8;
endpackage

// File: rtl/rate_tracking_lockable_lock_fsm.sv
// Lock state machine: counts in-tolerance recovered edges to reach TRACK and
// missed local edges to fall into HOLDOVER.
module rate_lock_fsm
    import clks_alot_p::*;
#(
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int unsigned MISS_LIMIT = MISS_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              generation_en,
    input  logic              rec_edge,
    input  logic              local_edge,
    input  logic              in_tol,
    output rate_track_state_e state
);
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [7:0] MISS_LAST = 8'(MISS_LIMIT - 1);

    logic [7:0] lock_cnt;
    logic [7:0] miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_cnt <= '0;
            miss_cnt <= '0;
        end else if (clk_en) begin
            if (!generation_en) begin
                state    <= IDLE;
                lock_cnt <= '0;
                miss_cnt <= '0;
            end else begin
                case (state)
                    IDLE: state <= ACQUIRE;
                    ACQUIRE: begin
                        if (rec_edge) begin
                            if (!in_tol) begin
                                lock_cnt <= '0;
                            end else if (lock_cnt == LOCK_LAST) begin
                                state    <= TRACK;
                                lock_cnt <= '0;
                                miss_cnt <= '0;
                            end else begin
                                lock_cnt <= lock_cnt + 8'd1;
                            end
                        end
                    end
                    TRACK: begin
                        // A recovered edge always clears misses, even one coincident with a local edge
                        if (rec_edge) begin
                            miss_cnt <= '0;
                            if (!in_tol) begin
                                state    <= ACQUIRE;
                                lock_cnt <= '0;
                            end
                        end else if (local_edge) begin
                            if (miss_cnt == MISS_LAST) begin
                                state    <= HOLDOVER;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 8'd1;
                            end
                        end
                    end
                    HOLDOVER: begin
                        if (rec_edge) begin
                            state    <= ACQUIRE;
                            lock_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/rate_tracking_lockable.sv
// Half-rate target tracker with lock FSM; resyncs on recovered edges and free-runs
// on local edges. Optional drift trim enabled by RATE_TRACKING_DRIFT_TRIM_EN.
module rate_tracking_lockable
    import clks_alot_p::*;
#(
    parameter int unsigned RATE_WIDTH = 16,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int unsigned ERR_TOL    = ERR_TOL_DEF,
    parameter int unsigned MISS_LIMIT = MISS_LIMIT_DEF
) (
    input  common_p::clk_dom_s     sys_dom_i,
    input  logic                   generation_en_i,
    input  logic                   clear_state_i,
    input  logic                   rec_edge_valid_i,
    input  logic                   rec_edge_rising_i,
    input  logic [RATE_WIDTH-1:0]  rising_delta_i,
    input  logic [RATE_WIDTH-1:0]  falling_delta_i,
    input  logic [RATE_WIDTH-1:0]  high_rate_i,
    input  logic [RATE_WIDTH-1:0]  low_rate_i,
    input  logic                   local_clk_i,
    input  logic                   local_edge_i,
    input  logic [RATE_WIDTH-1:0]  counter_current_i,
    output logic [RATE_WIDTH-1:0]  half_rate_target_o,
    output logic [RATE_WIDTH-1:0]  active_half_rate_o,
    output logic [RATE_WIDTH-1:0]  inactive_half_rate_o,
    output logic [RATE_WIDTH-1:0]  phase_error_o,
    output logic [1:0]             state_o,
    output logic                   locked_o
);
    localparam logic signed [RATE_WIDTH-1:0] TOL = RATE_WIDTH'(ERR_TOL);

    logic                         clk;
    logic                         clk_en;
    logic                         rst;
    rate_track_state_e            state;
    logic [RATE_WIDTH-1:0]        target;
    logic [RATE_WIDTH-1:0]        active_rate;
    logic [RATE_WIDTH-1:0]        inactive_rate;
    logic [RATE_WIDTH-1:0]        phase_err;
    logic signed [RATE_WIDTH-1:0] err;
    logic                         in_tol;
    logic                         live;
    logic [RATE_WIDTH-1:0]        high_eff;
    logic [RATE_WIDTH-1:0]        low_eff;

    assign clk    = sys_dom_i.clk;
    assign clk_en = sys_dom_i.clk_en;
    assign rst    = sys_dom_i.sync_rst | (sys_dom_i.clk_en & clear_state_i);
    assign live   = generation_en_i && (state != IDLE);

    // Wrapped difference read as signed; -2^(W-1) falls below -TOL and so is out of tolerance
    assign err    = counter_current_i - target;
    assign in_tol = (err <= TOL) && (err >= -TOL);

`ifdef RATE_TRACKING_DRIFT_TRIM_EN
    logic signed [2:0]     trim;
    logic [RATE_WIDTH-1:0] trim_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            trim <= '0;
        end else if (clk_en) begin
            if (!generation_en_i || state != TRACK) begin
                trim <= '0;
            end else if (rec_edge_valid_i && in_tol && err != '0) begin
                if (err > 0 && trim != -3'sd3) begin
                    trim <= trim - 3'sd1;
                end else if (err < 0 && trim != 3'sd3) begin
                    trim <= trim + 3'sd1;
                end
            end
        end
    end

    // Mask on state too so the trim drops out the same cycle TRACK is left
    assign trim_ext = (state == TRACK) ? {{(RATE_WIDTH-3){trim[2]}}, trim} : '0;
    assign high_eff = high_rate_i + trim_ext;
    assign low_eff  = low_rate_i + trim_ext;
`else
    assign high_eff = high_rate_i;
    assign low_eff  = low_rate_i;
`endif

    rate_lock_fsm #(
        .LOCK_COUNT (LOCK_COUNT),
        .MISS_LIMIT (MISS_LIMIT)
    ) u_lock_fsm (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .generation_en (generation_en_i),
        .rec_edge      (rec_edge_valid_i),
        .local_edge    (local_edge_i),
        .in_tol        (in_tol),
        .state         (state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            target        <= '0;
            active_rate   <= '0;
            inactive_rate <= '0;
            phase_err     <= '0;
        end else if (clk_en && live) begin
            if (rec_edge_valid_i) begin
                target    <= counter_current_i + (rec_edge_rising_i ? rising_delta_i : falling_delta_i);
                phase_err <= err;
            end else if (local_edge_i) begin
                target    <= counter_current_i + (local_clk_i ? low_eff : high_eff);
            end
            if (local_edge_i) begin
                active_rate   <= local_clk_i ? low_eff : high_eff;
                inactive_rate <= local_clk_i ? high_eff : low_eff;
            end
        end
    end

    assign half_rate_target_o   = target;
    assign active_half_rate_o   = active_rate;
    assign inactive_half_rate_o = inactive_rate;
    assign phase_error_o        = phase_err;
    assign state_o              = state;
    assign locked_o             = (state == TRACK);
endmodule

// File: tb/tb_rate_tracking_lockable.sv
// Bench for rate_tracking_lockable: directed vector table, hand sequences for
// holdover and tolerance edges, then randomized traffic against a reference model.
module tb_rate_tracking_lockable;
    logic        clk = 1'b0;
    logic        rst, en, clr, gen, rec, rising, loc, lclk;
    logic [15:0] rd, fd, hr, lr, cnt;
    logic [15:0] tgt_o, act_o, inact_o, perr_o;
    logic [1:0]  st_o;
    logic        lk_o;
    common_p::clk_dom_s dom;

    assign dom = {clk, rst, en};
    always #5 clk = ~clk;

    rate_tracking_lockable #(
        .RATE_WIDTH (16),
        .LOCK_COUNT (4),
        .ERR_TOL    (2),
        .MISS_LIMIT (8)
    ) dut (
        .sys_dom_i            (dom),
        .generation_en_i      (gen),
        .clear_state_i        (clr),
        .rec_edge_valid_i     (rec),
        .rec_edge_rising_i    (rising),
        .rising_delta_i       (rd),
        .falling_delta_i      (fd),
        .high_rate_i          (hr),
        .low_rate_i           (lr),
        .local_clk_i          (lclk),
        .local_edge_i         (loc),
        .counter_current_i    (cnt),
        .half_rate_target_o   (tgt_o),
        .active_half_rate_o   (act_o),
        .inactive_half_rate_o (inact_o),
        .phase_error_o        (perr_o),
        .state_o              (st_o),
        .locked_o             (lk_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: state 0 idle, 1 acquiring, 2 tracking, 3 holdover
    int m_st, m_lock, m_miss, m_tgt, m_act, m_inact, m_perr;

    function automatic int wrap(input int v);
        return v & 32'h0000FFFF;
    endfunction

    task automatic model_update();
        int c, e;
        bit tol;
        if (rst || (en && clr)) begin
            m_st = 0; m_lock = 0; m_miss = 0;
            m_tgt = 0; m_act = 0; m_inact = 0; m_perr = 0;
            return;
        end
        if (!en) return;
        if (!gen) begin
            m_st = 0; m_lock = 0; m_miss = 0;
            return;
        end
        if (m_st == 0) begin
            m_st = 1;
            return;
        end
        c = int'(cnt);
        e = wrap(c - m_tgt);
        if (e >= 32768) e = e - 65536;
        tol = (e >= -2) && (e <= 2);
        if (rec) begin
            m_perr = wrap(e);
            m_tgt  = wrap(c + int'(rising ? rd : fd));
        end else if (loc) begin
            m_tgt  = wrap(c + int'(lclk ? lr : hr));
        end
        if (loc) begin
            m_act   = int'(lclk ? lr : hr);
            m_inact = int'(lclk ? hr : lr);
        end
        if (m_st == 1) begin
            if (rec) begin
                m_lock = tol ? m_lock + 1 : 0;
                if (m_lock == 4) begin m_st = 2; m_lock = 0; m_miss = 0; end
            end
        end else if (m_st == 2) begin
            if (rec) begin
                m_miss = 0;
                if (!tol) begin m_st = 1; m_lock = 0; end
            end else if (loc) begin
                m_miss++;
                if (m_miss == 8) begin m_st = 3; m_miss = 0; end
            end
        end else if (m_st == 3) begin
            if (rec) begin m_st = 1; m_lock = 0; end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic check_model(input string nm);
        chk({nm, ".target"},   32'(tgt_o),   32'(m_tgt));
        chk({nm, ".active"},   32'(act_o),   32'(m_act));
        chk({nm, ".inactive"}, 32'(inact_o), 32'(m_inact));
        chk({nm, ".perr"},     32'(perr_o),  32'(m_perr));
        chk({nm, ".state"},    32'(st_o),    32'(m_st));
        chk({nm, ".locked"},   32'(lk_o),    32'(m_st == 2));
    endtask

    typedef struct {
        logic        rst, en, clr, gen, rec, rising, loc, lclk;
        logic [15:0] cnt;
        int          st, tgt, act, inact, perr;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, e, c, g, rc, ri, lo, lc, input int cn,
                       input int st, tg, ac, ia, pe);
        vec_t v;
        v.rst = r; v.en = e; v.clr = c; v.gen = g; v.rec = rc; v.rising = ri;
        v.loc = lo; v.lclk = lc; v.cnt = 16'(cn);
        v.st = st; v.tgt = tg; v.act = ac; v.inact = ia; v.perr = pe;
        vecs.push_back(v);
    endtask

    task automatic quiet();
        rst = 0; en = 1; clr = 0; gen = 1; rec = 0; rising = 0; loc = 0; lclk = 0;
    endtask

    initial begin
        quiet();
        rst = 1; cnt = 16'd100;
        hr = 16'd10; lr = 16'd6; rd = 16'd7; fd = 16'd3;

        //  rst en clr gen rec ris loc lclk cnt      st  tgt act ina perr
        add(1, 1, 0, 1, 0, 0, 0, 0, 100,      0,   0,  0,  0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0, 100,      1,   0,  0,  0, 0);
        add(0, 1, 0, 1, 1, 1, 0, 0, 1,        1,   8,  0,  0, 1);
        add(0, 1, 0, 1, 1, 1, 0, 0, 9,        1,  16,  0,  0, 1);
        add(0, 1, 0, 1, 1, 1, 0, 0, 17,       1,  24,  0,  0, 1);
        add(0, 1, 0, 1, 1, 1, 0, 0, 25,       2,  32,  0,  0, 1);
        add(0, 1, 0, 1, 0, 0, 1, 0, 'hFFFA,   2,   4, 10,  6, 1);
        add(0, 1, 0, 1, 1, 0, 0, 0, 3,        2,   6, 10,  6, 'hFFFF);
        add(0, 1, 0, 1, 1, 1, 1, 1, 50,       1,  57,  6, 10, 44);
        add(0, 1, 0, 1, 0, 0, 0, 0, 999,      1,  57,  6, 10, 44);
        add(0, 1, 0, 1, 1, 1, 0, 0, 58,       1,  65,  6, 10, 1);
        add(0, 1, 0, 1, 1, 1, 0, 0, 66,       1,  73,  6, 10, 1);
        add(0, 1, 0, 1, 1, 1, 0, 0, 78,       1,  85,  6, 10, 5);
        add(0, 1, 0, 1, 1, 1, 0, 0, 86,       1,  93,  6, 10, 1);
        add(0, 1, 0, 1, 1, 1, 0, 0, 94,       1, 101,  6, 10, 1);
        add(0, 1, 0, 1, 1, 1, 0, 0, 102,      1, 109,  6, 10, 1);
        add(0, 1, 0, 1, 1, 1, 0, 0, 110,      2, 117,  6, 10, 1);
        for (int k = 0; k < 5; k++)
            add(0, 0, logic'(k == 4), 1, 1, k[0], 1, k[1], 500 + k, 2, 117, 6, 10, 1);
        add(0, 1, 1, 1, 1, 1, 1, 0, 500,      0,   0,  0,  0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0, 0,        1,   0,  0,  0, 0);
        add(0, 1, 0, 1, 1, 1, 0, 0, 1,        1,   8,  0,  0, 1);
        add(0, 1, 0, 0, 1, 1, 1, 0, 20,       0,   8,  0,  0, 1);
        add(0, 1, 0, 1, 1, 1, 1, 0, 40,       1,   8,  0,  0, 1);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; en = vecs[i].en; clr = vecs[i].clr; gen = vecs[i].gen;
            rec = vecs[i].rec; rising = vecs[i].rising; loc = vecs[i].loc;
            lclk = vecs[i].lclk; cnt = vecs[i].cnt;
            tick();
            chk($sformatf("vec%0d.state", i),    32'(st_o),    32'(vecs[i].st));
            chk($sformatf("vec%0d.locked", i),   32'(lk_o),    32'(vecs[i].st == 2));
            chk($sformatf("vec%0d.target", i),   32'(tgt_o),   32'(vecs[i].tgt));
            chk($sformatf("vec%0d.active", i),   32'(act_o),   32'(vecs[i].act));
            chk($sformatf("vec%0d.inactive", i), 32'(inact_o), 32'(vecs[i].inact));
            chk($sformatf("vec%0d.perr", i),     32'(perr_o),  32'(vecs[i].perr));
        end

        // Holdover: lock, miss 8 local edges, free-run one more, then resync
        quiet(); rst = 1; tick(); rst = 0; tick();
        for (int i = 0; i < 4; i++) begin
            rec = 1; rising = 1; cnt = 16'(7 * i);
            tick();
            chk("lock.target", 32'(tgt_o), 32'(7 * (i + 1)));
        end
        chk("lock.state", 32'(st_o), 32'd2);
        rec = 0;
        for (int i = 0; i < 9; i++) begin
            loc = 1; lclk = i[0]; cnt = 16'(100 * i);
            tick();
            chk($sformatf("miss%0d.target", i), 32'(tgt_o), 32'(100 * i + (i[0] ? 6 : 10)));
            chk($sformatf("miss%0d.state", i), 32'(st_o), (i < 7) ? 32'd2 : 32'd3);
            check_model("miss");
        end
        loc = 0; rec = 1; rising = 0; cnt = 16'd1000;
        tick();
        chk("hold_exit.state",  32'(st_o),   32'd1);
        chk("hold_exit.target", 32'(tgt_o),  32'd1003);
        chk("hold_exit.perr",   32'(perr_o), 32'd190);

        // Error of exactly -2^15 is out of tolerance; +/-2 is in tolerance
        rising = 1; cnt = 16'(1003 + 32768);
        tick();
        chk("minneg.perr",  32'(perr_o), 32'h8000);
        chk("minneg.state", 32'(st_o),   32'd1);
        for (int i = 0; i < 4; i++) begin
            cnt = 16'(int'(tgt_o) + (i[0] ? -2 : 2));
            tick();
            chk($sformatf("tol%0d.state", i), 32'(st_o), (i < 3) ? 32'd1 : 32'd2);
            check_model("tol");
        end

        // Randomized traffic against the reference model
        quiet();
        for (int n = 0; n < 4000; n++) begin
            int p, r;
            p = ((n / 250) % 2 == 1) ? 3 : 35;
            rst    = ($urandom_range(0, 499) == 0);
            clr    = ($urandom_range(0, 299) == 0);
            en     = ($urandom_range(0, 9) != 0);
            gen    = ($urandom_range(0, 99) != 0);
            rec    = (int'($urandom_range(0, 99)) < p);
            rising = 1'($urandom);
            loc    = ($urandom_range(0, 99) < 40);
            lclk   = 1'($urandom);
            hr = 16'($urandom); lr = 16'($urandom);
            rd = 16'($urandom); fd = 16'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 8)       cnt = 16'(m_tgt + int'($urandom_range(0, 6)) - 3);
            else if (r == 8) cnt = 16'(m_tgt + 32768);
            else             cnt = 16'($urandom);
            tick();
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rate_tracking_lockable.md
Name: rate_tracking_lockable

Overview:
Parametrised successor to the clock-generation half-rate tracker. It holds the absolute counter target for the next generated edge and the active/inactive half-rates, and resyncs the target to recovered edges. It adds a lock state machine (IDLE/ACQUIRE/TRACK/HOLDOVER) driven by measured phase error, with miss counting so generation free-runs through gaps in the recovered clock. It sits between the rate counter and the edge generator in the generation path.

Parameters:
RATE_WIDTH, 16, width of all rate, delta, counter and target values.
LOCK_COUNT, 4, number of consecutive in-tolerance recovered edges needed to enter TRACK (1..255).
ERR_TOL, 2, largest |phase error| in counts that still counts as in-tolerance.
MISS_LIMIT, 8, number of consecutive local edges with no recovered edge that moves TRACK to HOLDOVER (1..255).

Ports:
sys_dom_i.clk  in  1  system clock (common_p::clk_dom_s member)
sys_dom_i.sync_rst  in  1  synchronous active-high reset (member)
sys_dom_i.clk_en  in  1  clock enable (member); when low, no state changes except reset
generation_en_i  in  1  generation enable; low forces IDLE
clear_state_i  in  1  soft clear, same effect as reset
rec_edge_valid_i  in  1  recovered edge strobe
rec_edge_rising_i  in  1  recovered edge polarity (1 = rising), valid with strobe
rising_delta_i  in  RATE_WIDTH  resync offset applied on a rising recovered edge
falling_delta_i  in  RATE_WIDTH  resync offset applied on a falling recovered edge
high_rate_i  in  RATE_WIDTH  high half-period
low_rate_i  in  RATE_WIDTH  low half-period
local_clk_i  in  1  current generated clock level
local_edge_i  in  1  generated clock edge strobe
counter_current_i  in  RATE_WIDTH  free-running rate counter
half_rate_target_o  out  RATE_WIDTH  absolute counter value of the next edge
active_half_rate_o  out  RATE_WIDTH  half-rate now in progress
inactive_half_rate_o  out  RATE_WIDTH  the other half-rate
phase_error_o  out  RATE_WIDTH  signed error (counter − target) latched on each recovered edge
state_o  out  2  0 IDLE, 1 ACQUIRE, 2 TRACK, 3 HOLDOVER
locked_o  out  1  state_o == TRACK

Behaviour:
- Reset (sync_rst, or clk_en && clear_state_i): all outputs 0, state IDLE, lock and miss counters 0. Reset takes priority over every other event.
- All updates are registered, so outputs change 1 cycle after the qualifying strobe. Strobes count only when clk_en = 1.
- IDLE: targets frozen. When generation_en_i = 1, go to ACQUIRE next cycle. In any state, generation_en_i = 0 returns to IDLE next cycle; outputs hold their values and counters clear.
- Phase error on rec_edge_valid_i (non-IDLE states): err = counter_current_i − half_rate_target_current, computed mod 2^W and read as signed. In-tolerance means |err| <= ERR_TOL. The magnitude of −2^(W−1) counts as out-of-tolerance.
- ACQUIRE: an in-tolerance edge increments lock_cnt; an out-of-tolerance edge clears it. When lock_cnt reaches LOCK_COUNT, go to TRACK.
- TRACK: an out-of-tolerance edge returns to ACQUIRE with lock_cnt = 0. Each local_edge_i with no recovered edge since the previous local edge increments miss_cnt; a recovered edge clears it. When miss_cnt reaches MISS_LIMIT, go to HOLDOVER.
- HOLDOVER: targets advance on local edges only. The first recovered edge goes to ACQUIRE with lock_cnt = 0 and is applied as a resync.
- Target mux, in priority order:
  - reset → 0.
  - Recovered edge in ACQUIRE or HOLDOVER → counter + (rec_edge_rising_i ? rising_delta_i : falling_delta_i).
  - Recovered edge in TRACK → also a resync.
  - Local edge → counter + (local_clk_i ? low_rate_i : high_rate_i).
  - All additions wrap mod 2^W.
- Simultaneous recovered and local edge: the resync target wins, the active/inactive update still happens, and miss_cnt clears.
- Active/inactive rates update on local_edge_i only:
  - local_clk_i = 0: active = high_rate_i, inactive = low_rate_i.
  - local_clk_i = 1: active = low_rate_i, inactive = high_rate_i.

Optional Feature:
RATE_TRACKING_DRIFT_TRIM_EN:
- When defined, in TRACK each in-tolerance recovered edge with err ≠ 0 adds a trim of −sign(err), saturated at ±3, to both high and low half-rates. The trimmed values are used for the calculated target and for active/inactive. The trim clears on leaving TRACK and on reset.
- When undefined, there is no trim logic and the half-rates are used unmodified.

Decomposition:
- clks_alot_p gets the typedef rate_track_state_e (IDLE/ACQUIRE/TRACK/HOLDOVER) and the default constants for LOCK_COUNT, ERR_TOL and MISS_LIMIT.
- One sub-module, rate_lock_fsm: the lock/miss counters and state transitions. Inputs are the in-tolerance flag and the strobes; outputs are the state.

Test Plan:
- Reset held with rates 10/6 and counter 100 → all outputs 0, state IDLE. Release with generation_en_i = 1 → state ACQUIRE after 1 cycle.
- ACQUIRE: 4 recovered edges, each with err = +1 (ERR_TOL 2) → state TRACK and locked_o = 1 one cycle after the 4th edge. An err of 5 on the 3rd edge → lock_cnt resets and TRACK is delayed accordingly.
- Target wrap: W = 16, counter 0xFFFA, local_clk_i = 0, high_rate_i 10 → target 0x0004. A recovered edge at counter 0x0003 then gives phase_error_o = 0xFFFF (−1).
- Simultaneous recovered rising edge (rising_delta_i 7, counter 50) and local edge, local_clk_i = 1 → target 57, active = low_rate_i, inactive = high_rate_i, miss_cnt = 0.
- TRACK with 8 local edges and no recovered edge → HOLDOVER, with the target still advancing. The next recovered edge → ACQUIRE plus a resync.
- clk_en = 0 for 5 cycles with strobes applied → no output changes. clear_state_i asserted during TRACK → all outputs zeroed.
